// File: rtl/rf_wb_pkg.sv
// Shared writeback/register-file widths and defaults.
// Imported by the writeback arbiter and the register-file users.
package rf_wb_pkg;

  localparam int NREQ_DEF       = 3;
  localparam int ADDR_WIDTH_DEF = 5;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int WEN_WIDTH      = 4;
  localparam int BYTE_CNT       = DATA_WIDTH_DEF / 8;
  localparam int STALL_W        = 16;

  // width of a pointer that indexes n requesters
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first request at/after the pointer wins,
// wrapping; next pointer is one past the winner.
module rr_arbiter
  import rf_wb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int PW   = ptr_width(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [PW-1:0]   ptr_o
);

  // scan from the pointer, grant the first requester found
  always_comb begin
    int idx;
    logic found;
    gnt_o = '0;
    ptr_o = ptr_i;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_i) + k) % NREQ;
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        ptr_o      = (idx == NREQ - 1) ? '0 : PW'(idx + 1);
      end
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter for the writeback sources.
// Optional RF_WB_ARB_STALL_CNT_EN adds per-source stall counters.
module rf_wb_arbiter
  import rf_wb_pkg::*;
#(
  parameter int NREQ       = NREQ_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       freeze,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ*ADDR_WIDTH-1:0] req_waddr,
  input  logic [NREQ*WEN_WIDTH-1:0]  req_wen,
  input  logic [NREQ*DATA_WIDTH-1:0] req_wdata,
  output logic [ADDR_WIDTH-1:0]      rf_waddr,
  output logic [WEN_WIDTH-1:0]       rf_wen,
  output logic [DATA_WIDTH-1:0]      rf_wdata,
  output logic [NREQ-1:0]            last_grant
`ifdef RF_WB_ARB_STALL_CNT_EN
  ,
  output logic [NREQ*STALL_W-1:0]    stall_cnt
`endif
);

  localparam int PW = ptr_width(NREQ);

  logic [NREQ-1:0]       req_m;
  logic [NREQ-1:0]       gnt;
  logic [PW-1:0]         ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [WEN_WIDTH-1:0]  wen_q, wen_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [NREQ-1:0]       last_q, last_d;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [WEN_WIDTH-1:0]  sel_wen;
  logic [DATA_WIDTH-1:0] sel_data;

  assign req_m = (rst || freeze) ? '0 : req_valid;

  rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr (
    .req_i (req_m),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .ptr_o (ptr_d)
  );

  assign req_ready = gnt;

  // one-hot AND-OR mux of the granted source's payload
  always_comb begin
    sel_addr = '0;
    sel_wen  = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_addr = sel_addr | req_waddr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wen  = sel_wen  | req_wen[i*WEN_WIDTH +: WEN_WIDTH];
        sel_data = sel_data | req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // next write-port state; r0 writes are squashed, idle holds addr/data
  always_comb begin
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    wen_d   = '0;
    last_d  = gnt;
    if (|gnt) begin
      waddr_d = sel_addr;
      wdata_d = sel_data;
      wen_d   = (sel_addr == '0) ? '0 : sel_wen;
    end
  end

  // write-port and pointer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= '0;
      waddr_q <= '0;
      wen_q   <= '0;
      wdata_q <= '0;
      last_q  <= '0;
    end else begin
      ptr_q   <= ptr_d;
      waddr_q <= waddr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      last_q  <= last_d;
    end
  end

  assign rf_waddr   = waddr_q;
  assign rf_wen     = wen_q;
  assign rf_wdata   = wdata_q;
  assign last_grant = last_q;

`ifdef RF_WB_ARB_STALL_CNT_EN
  logic [STALL_W-1:0] stall_q [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_stall
    // count cycles a source waits, saturating at all-ones
    always_ff @(posedge clk) begin
      if (rst) begin
        stall_q[g] <= '0;
      end else if (req_valid[g] && !gnt[g] && (stall_q[g] != '1)) begin
        stall_q[g] <= stall_q[g] + 1'b1;
      end
    end
    assign stall_cnt[g*STALL_W +: STALL_W] = stall_q[g];
  end
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter against a behavioural
// round-robin model (directed scenarios plus randomized traffic).
module tb_rf_wb_arbiter;

  localparam int NREQ = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int WW   = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              freeze = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*AW-1:0] req_waddr = '0;
  logic [NREQ*WW-1:0] req_wen = '0;
  logic [NREQ*DW-1:0] req_wdata = '0;
  logic [AW-1:0]     rf_waddr;
  logic [WW-1:0]     rf_wen;
  logic [DW-1:0]     rf_wdata;
  logic [NREQ-1:0]   last_grant;
`ifdef RF_WB_ARB_STALL_CNT_EN
  logic [NREQ*16-1:0] stall_cnt;
`endif

  rf_wb_arbiter #(
    .NREQ       (NREQ),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .freeze     (freeze),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_waddr  (req_waddr),
    .req_wen    (req_wen),
    .req_wdata  (req_wdata),
    .rf_waddr   (rf_waddr),
    .rf_wen     (rf_wen),
    .rf_wdata   (rf_wdata),
    .last_grant (last_grant)
`ifdef RF_WB_ARB_STALL_CNT_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // reference model state
  int              m_ptr = 0;
  logic [AW-1:0]   m_waddr = '0;
  logic [WW-1:0]   m_wen = '0;
  logic [DW-1:0]   m_wdata = '0;
  logic [NREQ-1:0] m_last = '0;
  int              m_stall [NREQ];

  function automatic logic [NREQ-1:0] exp_grant();
    logic [NREQ-1:0] g;
    g = '0;
    if (rst || freeze) return g;
    for (int k = 0; k < NREQ; k++) begin
      int s;
      s = (m_ptr + k) % NREQ;
      if (req_valid[s]) begin
        g[s] = 1'b1;
        return g;
      end
    end
    return g;
  endfunction

  // one clock: sample inputs, advance the model, land at posedge+1
  task automatic advance();
    logic [NREQ-1:0] g;
    logic [NREQ-1:0] v;
    logic            r;
    int              s;
    g = exp_grant();
    v = req_valid;
    r = rst;
    s = -1;
    for (int i = 0; i < NREQ; i++) if (g[i]) s = i;
    if (s >= 0) begin
      m_waddr = req_waddr[s*AW +: AW];
      m_wdata = req_wdata[s*DW +: DW];
      m_wen   = (m_waddr == 0) ? '0 : req_wen[s*WW +: WW];
    end
    @(posedge clk);
    #1;
    if (r) begin
      m_ptr = 0; m_waddr = '0; m_wen = '0; m_wdata = '0; m_last = '0;
      for (int i = 0; i < NREQ; i++) m_stall[i] = 0;
    end else begin
      if (s >= 0) m_ptr = (s + 1) % NREQ;
      else m_wen = '0;
      m_last = g;
      for (int i = 0; i < NREQ; i++)
        if (v[i] && !g[i] && m_stall[i] < 65535) m_stall[i]++;
    end
  endtask

  task automatic set_src(input int i, input logic [AW-1:0] a,
                         input logic [WW-1:0] w, input logic [DW-1:0] d);
    req_waddr[i*AW +: AW] = a;
    req_wen[i*WW +: WW]   = w;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    freeze = 1'b0;
    req_valid = '0;
    advance();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '1;
    #1;
    tests++;
    if (req_ready !== '0) begin
      fails++;
      $display("FAIL reset_ready: got %b expected 000", req_ready);
    end
    advance();
    advance();
    req_valid = '0;
    rst = 1'b0;
    #1;
    tests++;
    if ({rf_waddr, rf_wen, rf_wdata, last_grant} !== '0) begin
      fails++;
      $display("FAIL reset_out: got %h %h %h %b expected zeros",
               rf_waddr, rf_wen, rf_wdata, last_grant);
    end
  endtask

  task automatic test_single();
    do_reset();
    set_src(1, 5'd5, 4'hF, 32'hDEADBEEF);
    req_valid = 3'b010;
    #1;
    tests++;
    if (req_ready !== 3'b010) begin
      fails++;
      $display("FAIL single_ready: got %b expected 010", req_ready);
    end
    advance();
    req_valid = '0;
    tests++;
    if (rf_waddr !== 5'd5 || rf_wen !== 4'hF || rf_wdata !== 32'hDEADBEEF
        || last_grant !== 3'b010) begin
      fails++;
      $display("FAIL single_out: got %h %h %h %b expected 05 f deadbeef 010",
               rf_waddr, rf_wen, rf_wdata, last_grant);
    end
    advance();
    tests++;
    if (rf_wen !== 4'h0 || rf_waddr !== 5'd5) begin
      fails++;
      $display("FAIL idle_hold: got wen %h addr %h expected 0 05",
               rf_wen, rf_waddr);
    end
  endtask

  task automatic test_round_robin();
    int order [6] = '{0, 1, 2, 0, 1, 2};
    do_reset();
    for (int i = 0; i < NREQ; i++) set_src(i, AW'(i + 1), 4'hF, DW'(i * 17));
    req_valid = '1;
    for (int c = 0; c < 6; c++) begin
      #1;
      tests++;
      if (req_ready !== NREQ'(1 << order[c])) begin
        fails++;
        $display("FAIL rr_grant%0d: got %b expected src %0d",
                 c, req_ready, order[c]);
      end
      advance();
      tests++;
      if (last_grant !== NREQ'(1 << order[c]) || rf_waddr !== AW'(order[c] + 1)) begin
        fails++;
        $display("FAIL rr_last%0d: got %b addr %h expected src %0d",
                 c, last_grant, rf_waddr, order[c]);
      end
    end
    req_valid = '0;
  endtask

  task automatic test_r0();
    do_reset();
    set_src(0, 5'd0, 4'hF, 32'h12345678);
    req_valid = 3'b001;
    #1;
    tests++;
    if (req_ready !== 3'b001) begin
      fails++;
      $display("FAIL r0_ready: got %b expected 001", req_ready);
    end
    advance();
    req_valid = '0;
    tests++;
    if (rf_wen !== 4'h0 || last_grant !== 3'b001) begin
      fails++;
      $display("FAIL r0_wen: got %h %b expected 0 001", rf_wen, last_grant);
    end
  endtask

  task automatic test_wen_zero();
    do_reset();
    set_src(0, 5'd7, 4'h0, 32'hCAFE0000);
    set_src(1, 5'd9, 4'h3, 32'h0000BEEF);
    req_valid = 3'b011;
    #1;
    tests++;
    if (req_ready !== 3'b001) begin
      fails++;
      $display("FAIL wen0_ready: got %b expected 001", req_ready);
    end
    advance();
    req_valid = 3'b010;
    #1;
    tests++;
    if (rf_wen !== 4'h0 || rf_waddr !== 5'd7 || req_ready !== 3'b010) begin
      fails++;
      $display("FAIL wen0_out: got wen %h addr %h rdy %b expected 0 07 010",
               rf_wen, rf_waddr, req_ready);
    end
    advance();
    req_valid = '0;
    tests++;
    if (rf_wen !== 4'h3 || rf_wdata !== 32'h0000BEEF) begin
      fails++;
      $display("FAIL wen0_next: got %h %h expected 3 0000beef", rf_wen, rf_wdata);
    end
  endtask

  task automatic test_freeze();
    do_reset();
    set_src(0, 5'd1, 4'hF, 32'h1);
    set_src(1, 5'd2, 4'hF, 32'h2);
    set_src(2, 5'd3, 4'hF, 32'h3);
    req_valid = 3'b001;
    advance();
    req_valid = 3'b100;
    freeze = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      tests++;
      if (req_ready !== '0) begin
        fails++;
        $display("FAIL frz_ready%0d: got %b expected 000", c, req_ready);
      end
      advance();
      tests++;
      if (rf_wen !== 4'h0) begin
        fails++;
        $display("FAIL frz_wen%0d: got %h expected 0", c, rf_wen);
      end
    end
    freeze = 1'b0;
    #1;
    tests++;
    if (req_ready !== 3'b100) begin
      fails++;
      $display("FAIL frz_release: got %b expected 100", req_ready);
    end
    advance();
    req_valid = '1;
    freeze = 1'b1;
    advance();
    advance();
    freeze = 1'b0;
    #1;
    tests++;
    if (req_ready !== 3'b001) begin
      fails++;
      $display("FAIL frz_ptr_hold: got %b expected 001", req_ready);
    end
    advance();
    req_valid = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < NREQ; i++) set_src(i, AW'(i + 4), 4'hF, DW'(i));
    req_valid = '1;
    advance();
    rst = 1'b1;
    #1;
    tests++;
    if (req_ready !== '0) begin
      fails++;
      $display("FAIL rstmid_ready: got %b expected 000", req_ready);
    end
    advance();
    rst = 1'b0;
    #1;
    tests++;
    if (rf_wen !== 4'h0 || last_grant !== '0 || req_ready !== 3'b001) begin
      fails++;
      $display("FAIL rstmid_out: got wen %h last %b rdy %b expected 0 000 001",
               rf_wen, last_grant, req_ready);
    end
    advance();
    req_valid = '0;
  endtask

  task automatic test_random();
    int errs;
    logic [NREQ-1:0] g;
    errs = 0;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      #1;
      g = exp_grant();
      tests++;
      if (req_ready !== g) begin
        fails++;
        errs++;
        if (errs < 10)
          $display("FAIL rand_ready c%0d: got %b expected %b", c, req_ready, g);
      end
      advance();
      tests++;
      if (rf_waddr !== m_waddr || rf_wen !== m_wen || rf_wdata !== m_wdata
          || last_grant !== m_last) begin
        fails++;
        errs++;
        if (errs < 10)
          $display("FAIL rand_out c%0d: got %h %h %h %b expected %h %h %h %b",
                   c, rf_waddr, rf_wen, rf_wdata, last_grant,
                   m_waddr, m_wen, m_wdata, m_last);
      end
      freeze = ($urandom_range(7) == 0);
      for (int i = 0; i < NREQ; i++) begin
        if (!(req_valid[i] && !g[i])) begin
          req_valid[i] = ($urandom_range(3) != 0);
          set_src(i, AW'($urandom_range(31)), WW'($urandom_range(15)), $urandom);
        end
      end
    end
    req_valid = '0;
    freeze = 1'b0;
  endtask

`ifdef RF_WB_ARB_STALL_CNT_EN
  task automatic test_stall_cnt();
    do_reset();
    set_src(0, 5'd1, 4'hF, 32'h1);
    set_src(1, 5'd2, 4'hF, 32'h2);
    req_valid = 3'b011;
    freeze = 1'b1;
    repeat (4) advance();
    freeze = 1'b0;
    advance();
    req_valid = 3'b010;
    advance();
    req_valid = '0;
    tests++;
    if (stall_cnt[16 +: 16] !== 16'd5 || m_stall[1] != 5) begin
      fails++;
      $display("FAIL stall_five: got %0d expected 5", stall_cnt[16 +: 16]);
    end
    req_valid = 3'b010;
    freeze = 1'b1;
    repeat (70000) advance();
    freeze = 1'b0;
    req_valid = '0;
    tests++;
    if (stall_cnt[16 +: 16] !== 16'hFFFF) begin
      fails++;
      $display("FAIL stall_sat: got %h expected ffff", stall_cnt[16 +: 16]);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < NREQ; i++) m_stall[i] = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_r0();
    test_wen_zero();
    test_freeze();
    test_reset_mid();
    test_random();
`ifdef RF_WB_ARB_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
